// File: rtl/tsu_pkg.sv
// tsu_pkg: shared FSM states, port IDs and queue widths for the TSU queue arbiter.
package tsu_pkg;
    typedef enum logic [1:0] {IDLE, POP, WAIT, HOLD} state_t;
    localparam logic PORT_RX = 1'b0;
    localparam logic PORT_TX = 1'b1;
    localparam int Q_DATA_W = 64;
    localparam int Q_STAT_W = 8;
endpackage

// File: rtl/tsu_queue_arb.sv
// tsu_queue_arb: round-robin drain of the RX/TX TSU queues into one valid/ready timestamp stream.
// Optional per-port pop counters are enabled with TSU_QUEUE_ARB_CNT_EN.
module tsu_queue_arb
    import tsu_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic                q_rd_clk,
    input  logic                q_rst,
    input  logic [Q_STAT_W-1:0] rx_q_rd_stat,
    input  logic [Q_DATA_W-1:0] rx_q_rd_data,
    output logic                rx_q_rd_en,
    input  logic [Q_STAT_W-1:0] tx_q_rd_stat,
    input  logic [Q_DATA_W-1:0] tx_q_rd_data,
    output logic                tx_q_rd_en,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [Q_DATA_W-1:0] ts_data,
    output logic                ts_port
`ifdef TSU_QUEUE_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0]    rx_cnt,
    output logic [CNT_W-1:0]    tx_cnt
`endif
);
    state_t     state;
    logic       pri;
    logic       armed;
    logic       port_q;
    logic [1:0] wait_cnt;
    logic       rx_ne;
    logic       tx_ne;
    logic       gnt;

    assign rx_ne = |rx_q_rd_stat;
    assign tx_ne = |tx_q_rd_stat;
    assign gnt   = (rx_ne && tx_ne) ? pri : tx_ne;

    // armed delays the first grant to the second edge after reset release
    always_ff @(posedge q_rd_clk or posedge q_rst) begin
        if (q_rst) begin
            state      <= IDLE;
            pri        <= PORT_RX;
            armed      <= 1'b0;
            port_q     <= PORT_RX;
            wait_cnt   <= 2'd0;
            rx_q_rd_en <= 1'b0;
            tx_q_rd_en <= 1'b0;
            ts_valid   <= 1'b0;
            ts_data    <= '0;
            ts_port    <= PORT_RX;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: if (armed && (rx_ne || tx_ne)) begin
                    port_q     <= gnt;
                    rx_q_rd_en <= (gnt == PORT_RX);
                    tx_q_rd_en <= (gnt == PORT_TX);
                    state      <= POP;
                end
                POP: begin
                    rx_q_rd_en <= 1'b0;
                    tx_q_rd_en <= 1'b0;
                    wait_cnt   <= 2'd0;
                    state      <= WAIT;
                end
                WAIT: if (wait_cnt == 2'(RD_LAT - 1)) begin
                    ts_data  <= (port_q == PORT_TX) ? tx_q_rd_data : rx_q_rd_data;
                    ts_port  <= port_q;
                    ts_valid <= 1'b1;
                    state    <= HOLD;
                end else begin
                    wait_cnt <= wait_cnt + 2'd1;
                end
                HOLD: if (ts_ready) begin
                    ts_valid <= 1'b0;
                    pri      <= ~ts_port;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef TSU_QUEUE_ARB_CNT_EN
    always_ff @(posedge q_rd_clk or posedge q_rst) begin
        if (q_rst) begin
            rx_cnt <= '0;
            tx_cnt <= '0;
        end else begin
            rx_cnt <= rx_cnt + CNT_W'(rx_q_rd_en);
            tx_cnt <= tx_cnt + CNT_W'(tx_q_rd_en);
        end
    end
`endif
endmodule

// File: tb/tb_tsu_queue_arb.sv
// tb_tsu_queue_arb: scoreboard bench for tsu_queue_arb with a latency-accurate queue model.
module tb_tsu_queue_arb;
    localparam int RD_LAT = 3;
    localparam int CNT_W  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_q_rd_stat, tx_q_rd_stat;
    logic [63:0] rx_q_rd_data, tx_q_rd_data;
    logic        rx_q_rd_en, tx_q_rd_en;
    logic        ts_valid, ts_port;
    logic        ts_ready = 1'b1;
    logic [63:0] ts_data;
`ifdef TSU_QUEUE_ARB_CNT_EN
    logic [CNT_W-1:0] rx_cnt, tx_cnt;
`endif

    logic [63:0] rx_vals [0:255];
    logic [63:0] tx_vals [0:255];
    logic [7:0]  rx_n = 8'd0, tx_n = 8'd0;
    logic [7:0]  rx_pops, tx_pops;
    logic [RD_LAT-1:0] rx_pipe, tx_pipe;
    logic [64:0] exp_q [$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tsu_queue_arb #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .q_rd_clk(clk), .q_rst(rst),
        .rx_q_rd_stat(rx_q_rd_stat), .rx_q_rd_data(rx_q_rd_data), .rx_q_rd_en(rx_q_rd_en),
        .tx_q_rd_stat(tx_q_rd_stat), .tx_q_rd_data(tx_q_rd_data), .tx_q_rd_en(tx_q_rd_en),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data), .ts_port(ts_port)
`ifdef TSU_QUEUE_ARB_CNT_EN
        , .rx_cnt(rx_cnt), .tx_cnt(tx_cnt)
`endif
    );

    // Queue model: read data is only correct RD_LAT cycles after the pop, junk before
    assign rx_q_rd_stat = rx_n - rx_pops;
    assign tx_q_rd_stat = tx_n - tx_pops;
    assign rx_q_rd_data = rx_pipe[RD_LAT-1] ? rx_vals[rx_pops - 8'd1] : (64'hBAD0_0000_0000_0000 | 64'(rx_pipe));
    assign tx_q_rd_data = tx_pipe[RD_LAT-1] ? tx_vals[tx_pops - 8'd1] : (64'hBAD1_0000_0000_0000 | 64'(tx_pipe));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_pops <= 8'd0;
            tx_pops <= 8'd0;
            rx_pipe <= '0;
            tx_pipe <= '0;
        end else begin
            rx_pops <= rx_pops + 8'(rx_q_rd_en);
            tx_pops <= tx_pops + 8'(tx_q_rd_en);
            rx_pipe <= {rx_pipe[RD_LAT-2:0], rx_q_rd_en};
            tx_pipe <= {tx_pipe[RD_LAT-2:0], tx_q_rd_en};
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted entry must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && ts_valid && ts_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_entry", ts_data, 64'hx);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("ts_data", ts_data, e[63:0]);
                chk("ts_port", 64'(ts_port), 64'(e[64]));
            end
        end
    end

    task automatic load(input logic port, input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            if (port) tx_vals[tx_n + 8'(i)] = base + 64'(i);
            else      rx_vals[rx_n + 8'(i)] = base + 64'(i);
        end
        if (port) tx_n = tx_n + 8'(n);
        else      rx_n = rx_n + 8'(n);
    endtask

    task automatic expect_entry(input logic port, input logic [63:0] d);
        exp_q.push_back({port, d});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        rx_n = 8'd0;
        tx_n = 8'd0;
        exp_q.delete();
        #1;
        chk("rst_ts_valid", 64'(ts_valid), 64'd0);
        chk("rst_rd_en", 64'({rx_q_rd_en, tx_q_rd_en}), 64'd0);
        chk("rst_ts_data", ts_data, 64'd0);
        chk("rst_ts_port", 64'(ts_port), 64'd0);
`ifdef TSU_QUEUE_ARB_CNT_EN
        chk("rst_cnt", 64'({rx_cnt, tx_cnt}), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int c;
        c = 0;
        while (c < maxc && !(exp_q.size() == 0 && !ts_valid)) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (c >= maxc) chk({nm, "_timeout"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_pulse(output int cyc);
        cyc = 0;
        while (cyc < 30 && !(rx_q_rd_en || tx_q_rd_en)) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (cyc >= 30) chk("pulse_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int c, t0;
        logic [63:0] snap;
        logic stable;

        // Single RX entry, first grant not on the first edge after release
        rst = 1'b1;
        do_reset();
        load(1'b0, 1, 64'hA5);
        expect_entry(1'b0, 64'hA5);
        @(posedge clk);
        #1 chk("no_grant_first_edge", 64'(rx_q_rd_en), 64'd0);
        wait_pulse(c);
        chk("single_rx_en", 64'({rx_q_rd_en, tx_q_rd_en}), 64'b10);
        t0 = 0;
        while (t0 < 20 && !ts_valid) begin
            @(posedge clk);
            #1 t0++;
        end
        chk("single_latency", 64'(t0), 64'(RD_LAT + 1));
        wait_idle(20, "single");
        chk("single_pops", 64'({rx_pops, tx_pops}), 64'h0100);

        // Contention: strict alternation starting with RX
        do_reset();
        load(1'b0, 4, 64'h1000);
        load(1'b1, 4, 64'h2000);
        for (int i = 0; i < 4; i++) begin
            expect_entry(1'b0, 64'h1000 + 64'(i));
            expect_entry(1'b1, 64'h2000 + 64'(i));
        end
        c = 0;
        while (c < 200 && !(exp_q.size() == 0 && !ts_valid)) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("fair_done", 64'(exp_q.size()), 64'd0);
        chk("fair_throughput_ok", 64'(c <= 8 * (RD_LAT + 3) + 2), 64'd1);
        chk("fair_pops", 64'({rx_pops, tx_pops}), 64'h0404);
`ifdef TSU_QUEUE_ARB_CNT_EN
        chk("fair_cnt", 64'({rx_cnt, tx_cnt}), 64'h44);
`endif

        // Backpressure: 20 stalled cycles in HOLD
        do_reset();
        ts_ready = 1'b0;
        load(1'b0, 1, 64'h1111);
        load(1'b1, 1, 64'h2222);
        expect_entry(1'b0, 64'h1111);
        expect_entry(1'b1, 64'h2222);
        c = 0;
        while (c < 30 && !ts_valid) begin
            @(posedge clk);
            #1 c++;
        end
        chk("bp_valid", 64'(ts_valid), 64'd1);
        snap = ts_data;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1 if (!ts_valid || ts_data !== snap || rx_q_rd_en || tx_q_rd_en) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        chk("bp_data", snap, 64'h1111);
        chk("bp_pops", 64'({rx_pops, tx_pops}), 64'h0100);
        ts_ready = 1'b1;
        wait_idle(40, "bp");
        chk("bp_pops_after", 64'({rx_pops, tx_pops}), 64'h0101);

        // Reset in WAIT with pri=1 beforehand; entry lost, pri back to RX
        do_reset();
        load(1'b0, 1, 64'h3333);
        expect_entry(1'b0, 64'h3333);
        wait_idle(30, "pre_wait");
        load(1'b0, 1, 64'hDEAD);
        wait_pulse(c);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midwait_valid", 64'(ts_valid), 64'd0);
        chk("midwait_en", 64'({rx_q_rd_en, tx_q_rd_en}), 64'd0);
        rx_n = 8'd0;
        tx_n = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        load(1'b0, 1, 64'h4444);
        load(1'b1, 1, 64'h5555);
        expect_entry(1'b0, 64'h4444);
        expect_entry(1'b1, 64'h5555);
        wait_idle(40, "post_rst");

        // Counter wrap: 17 RX pops
        do_reset();
        load(1'b0, 17, 64'h7000);
        for (int i = 0; i < 17; i++) expect_entry(1'b0, 64'h7000 + 64'(i));
        wait_idle(17 * (RD_LAT + 3) + 20, "wrap");
        chk("wrap_pops", 64'(rx_pops), 64'd17);
`ifdef TSU_QUEUE_ARB_CNT_EN
        chk("wrap_rx_cnt", 64'(rx_cnt), 64'd1);
        chk("wrap_tx_cnt", 64'(tx_cnt), 64'd0);
`endif

        chk("leftover", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tsu_queue_arb.md
TSU_QUEUE_ARB -- requirements
Module: tsu_queue_arb

Interface
REQ-001 Parameter RD_LAT, default 1, meaning: q_rd_clk cycles from a q_rd_en pulse to valid q_rd_data; legal range 1..3.
REQ-002 Parameter CNT_W, default 16, meaning: width of the per-port drain counters.
REQ-003 q_rd_clk  in  1  meaning: the single clock; all logic is on its rising edge.
REQ-004 q_rst  in  1  meaning: asynchronous, active-high reset.
REQ-005 rx_q_rd_stat  in  8  meaning: RX TSU queue fill level; 0 means empty.
REQ-006 rx_q_rd_data  in  64  meaning: RX TSU queue read data.
REQ-007 rx_q_rd_en  out  1  meaning: RX TSU queue pop strobe.
REQ-008 tx_q_rd_stat  in  8  meaning: TX TSU queue fill level; 0 means empty.
REQ-009 tx_q_rd_data  in  64  meaning: TX TSU queue read data.
REQ-010 tx_q_rd_en  out  1  meaning: TX TSU queue pop strobe.
REQ-011 ts_valid  out  1  meaning: an output timestamp entry is held.
REQ-012 ts_ready  in  1  meaning: the consumer accepts the entry.
REQ-013 ts_data  out  64  meaning: the captured queue entry.
REQ-014 ts_port  out  1  meaning: source of the entry; 0 = RX, 1 = TX.
REQ-015 rx_cnt, tx_cnt  out  CNT_W  meaning: entries popped per port (present only with TSU_QUEUE_ARB_CNT_EN).

Function
REQ-016 The FSM SHALL have four states, IDLE, POP, WAIT and HOLD, and a 1-bit priority register, pri (0 = RX preferred).
REQ-017 In IDLE:
- if exactly one stat is non-zero, that port SHALL be granted;
- if both are non-zero, port pri SHALL be granted;
- if both are zero, the FSM SHALL stay in IDLE.
- On a grant the FSM SHALL go to POP.
REQ-018 In POP, the granted port's q_rd_en SHALL be high for exactly one cycle; the other port's q_rd_en SHALL stay low; the next state SHALL be WAIT.
REQ-019 WAIT SHALL last RD_LAT cycles, counted by a 2-bit counter.
- On its last cycle the granted port's q_rd_data SHALL be registered into ts_data and the port into ts_port.
- The next state SHALL be HOLD.
REQ-020 In HOLD, ts_valid SHALL be 1, and ts_data and ts_port SHALL stay stable until ts_valid && ts_ready.
REQ-021 On the HOLD handshake:
- ts_valid SHALL fall;
- pri SHALL become the complement of the served port;
- the FSM SHALL return to IDLE.
REQ-022 The block SHALL never pop more than one entry per grant, and never pop a port whose stat read 0 in IDLE.
REQ-023 Minimum throughput SHALL be one entry per RD_LAT+3 cycles when ts_ready is held high.
REQ-024 Stat changes during POP, WAIT or HOLD SHALL be ignored; stat is sampled only in IDLE.
REQ-025 A ts_ready deassertion of any length in HOLD SHALL stall the FSM with no loss of data and no further pops.

Reset
REQ-026 While q_rst is high, the block SHALL hold the following values, regardless of clock:
- state = IDLE, pri = 0;
- both q_rd_en = 0, ts_valid = 0;
- ts_data = 0, ts_port = 0;
- rx_cnt = tx_cnt = 0.
REQ-027 A reset asserted in POP, WAIT or HOLD SHALL discard the in-flight entry; the popped queue entry is lost by design.
REQ-028 The first grant after reset release SHALL occur no earlier than the second rising edge after q_rst falls.

Configuration
REQ-029 With TSU_QUEUE_ARB_CNT_EN defined:
- rx_cnt and tx_cnt SHALL exist;
- each SHALL increment by 1 on the cycle of its port's q_rd_en;
- each SHALL wrap modulo 2^CNT_W.
REQ-030 Without TSU_QUEUE_ARB_CNT_EN, the counter ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 The package tsu_pkg SHALL hold the FSM state enum, the port-ID constants PORT_RX = 0 and PORT_TX = 1, and the queue data/stat width constants 64 and 8.
REQ-032 The block SHALL be a single module with no sub-modules; the 2-input round-robin grant is inline logic.

Verification
REQ-033 Single port: rx_stat = 1, tx_stat = 0, RX data = 64'hA5 -> one rx_q_rd_en pulse; ts_valid with ts_data = 64'hA5, ts_port = 0 at cycle 2+RD_LAT.
REQ-034 Contention fairness: both stats = 4, ts_ready = 1 for 8 entries -> ts_port sequence 0,1,0,1,0,1,0,1; rx_cnt = tx_cnt = 4.
REQ-035 Backpressure: ts_ready = 0 for 20 cycles in HOLD -> ts_data stable, zero q_rd_en pulses, then one handshake on ready.
REQ-036 Reset mid-WAIT: assert q_rst in WAIT -> ts_valid = 0, q_rd_en = 0, pri = 0 immediately; the next entry is served normally after release.
REQ-037 Counter wrap (CNT_EN, CNT_W = 4): 17 RX pops -> rx_cnt = 1.
REQ-038 RD_LAT = 3: the captured data SHALL equal the value presented three cycles after the pulse, not earlier values.
